mem_requester: RTL and testbench

Requester side of the 128-bit data memory port. It accepts single-word read/write requests from a cache or load/store unit over a valid/ready handshake. It drives the memory's registered-address, two-phase port with the correct cycle sequencing, then returns the read data or a write acknowledge over a valid/ready response channel. One request is outstanding at a time; a programmable extra wait models slow main memory.

---
 rtl/mem_requester.sv | 148 ++++++++++++++
 tb/tb_mem_requester.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - single-outstanding requester for a registered-address 128-bit memory port
//
// Accepts one read/write request at a time, sequences the memory through
// ADDR -> ACCESS -> WAIT, and returns read data or a write acknowledge.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_wr, req_addr, req_data  request kind, byte address, write data
//   resp_valid/resp_ready       response handshake
//   resp_data, resp_err         read data (0 for writes/errors), range error
//   mem_rd_wr, mem_we           memory direction and write enable
//   mem_addr, mem_data_wr       memory word address (nibble cleared), write data
//   mem_data_rd                 memory read data
module mem_requester #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned PHYS_WIDTH  = 10,
  parameter int unsigned MEM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  mem_rd_wr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  input  logic [DATA_WIDTH-1:0] mem_data_rd
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [3:0]            LAT       = MEM_LATENCY[3:0];
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~{{(ADDR_WIDTH-4){1'b0}}, 4'hF};

  logic [2:0]            state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  addr_oor;

  // Anything above the physical window means the request never touches memory.
  assign addr_oor = |req_addr[ADDR_WIDTH-1:PHYS_WIDTH+4];

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d        = req_wr;
          addr_d      = req_addr;
          data_d      = req_data;
          resp_data_d = '0;
          resp_err_d  = addr_oor;
          state_d     = addr_oor ? RESP : ADDR;
        end
      end
      ADDR:   state_d = ACCESS;
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = LAT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          resp_data_d = wr_q ? '0 : mem_data_rd;
          resp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= 4'd0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Memory port is a pure decode of state; ADDR keeps the enables low so the
  // memory can register the address before any write is allowed to fire.
  always_comb begin
    mem_rd_wr   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data_wr = '0;
    case (state_q)
      ADDR: mem_addr = addr_q & WORD_MASK;
      ACCESS: begin
        mem_addr    = addr_q & WORD_MASK;
        mem_rd_wr   = wr_q;
        mem_we      = wr_q;
        mem_data_wr = data_q;
      end
      WAIT: begin
        mem_addr  = addr_q & WORD_MASK;
        mem_rd_wr = wr_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - directed self-checking bench for mem_requester
module tb_mem_requester;

  logic         clk;
  logic [1:0]   rst_n;
  logic [1:0]   req_valid, req_ready, req_wr;
  logic [31:0]  req_addr [2];
  logic [127:0] req_data [2];
  logic [1:0]   resp_valid, resp_ready, resp_err;
  logic [127:0] resp_data [2];
  logic [1:0]   mem_rd_wr, mem_we;
  logic [31:0]  mem_addr [2];
  logic [127:0] mem_data_wr [2];
  logic [127:0] mem_data_rd [2];

  int n_checks = 0;
  int n_fails  = 0;
  int act0     = 0;

  localparam logic [127:0] D_A = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] D_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D_C = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] D_D = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D_E = 128'hCAFE_F00D_0000_0000_0000_0000_0000_00E1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_requester #(.MEM_LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]),
    .mem_rd_wr(mem_rd_wr[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_data_wr(mem_data_wr[0]), .mem_data_rd(mem_data_rd[0])
  );

  mem_requester #(.MEM_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]),
    .mem_rd_wr(mem_rd_wr[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_data_wr(mem_data_wr[1]), .mem_data_rd(mem_data_rd[1])
  );

  // Registered-address memory: address captured every edge, write on mem_we.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [127:0] m [1024];
    logic [31:0]  areg;
    initial begin
      for (int i = 0; i < 1024; i++) m[i] = '0;
      areg = '0;
    end
    always @(posedge clk) begin
      if (mem_we[g]) m[mem_addr[g][13:4]] <= mem_data_wr[g];
      areg <= mem_addr[g];
    end
    assign mem_data_rd[g] = m[areg[13:4]];
  end

  always @(negedge clk) if (mem_we[0] || mem_rd_wr[0]) act0 <= act0 + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance s with resp_ready high; lat counts edges
  // from the accept edge (inclusive) until resp_valid is seen.
  task automatic do_req(input int s, input logic wr, input logic [31:0] addr,
                        input logic [127:0] data, output int lat,
                        output logic [127:0] rd, output logic err);
    req_valid[s] = 1'b1;
    req_wr[s]    = wr;
    req_addr[s]  = addr;
    req_data[s]  = data;
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    req_wr[s]    = ~wr;
    req_addr[s]  = addr ^ 32'h0000_0030;
    req_data[s]  = ~data;
    lat = 1;
    while (!resp_valid[s] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = resp_data[s];
    err = resp_err[s];
    @(posedge clk); #1;
  endtask

  int           lat, snap;
  logic [127:0] rd;
  logic         err;

  initial begin
    rst_n      = 2'b00;
    req_valid  = 2'b00;
    req_wr     = 2'b00;
    resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0;
      req_data[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 2'b11;

    check("reset_req_ready", 128'(req_ready[0]), 128'd1);
    check("reset_resp_valid", 128'(resp_valid[0]), 128'd0);
    check("reset_resp_data", resp_data[0], 128'd0);
    check("reset_mem_we", 128'(mem_we[0]), 128'd0);
    check("reset_mem_addr", 128'(mem_addr[0]), 128'd0);

    // Write then read 0x20, latency 0.
    do_req(0, 1'b1, 32'h20, D_A, lat, rd, err);
    check("wr20_lat", 128'(lat), 128'd4);
    check("wr20_data", rd, 128'd0);
    check("wr20_err", 128'(err), 128'd0);
    check("ready_after_resp", 128'(req_ready[0]), 128'd1);
    do_req(0, 1'b0, 32'h20, '0, lat, rd, err);
    check("rd20_lat", 128'(lat), 128'd4);
    check("rd20_data", rd, D_A);
    check("rd20_err", 128'(err), 128'd0);

    // Low nibble ignored: write at 0x10, read back through 0x1F.
    do_req(0, 1'b1, 32'h10, D_B, lat, rd, err);
    do_req(0, 1'b0, 32'h1F, '0, lat, rd, err);
    check("rd1f_data", rd, D_B);

    // Last word with latency 3.
    do_req(1, 1'b1, 32'h3FF0, D_C, lat, rd, err);
    check("wr3ff0_lat", 128'(lat), 128'd7);
    do_req(1, 1'b0, 32'h3FF0, '0, lat, rd, err);
    check("rd3ff0_lat", 128'(lat), 128'd7);
    check("rd3ff0_data", rd, D_C);
    check("rd3ff0_err", 128'(err), 128'd0);

    // First out-of-range address: immediate error, no memory activity.
    snap = act0;
    do_req(0, 1'b0, 32'h4000, '0, lat, rd, err);
    check("oor_lat", 128'(lat), 128'd1);
    check("oor_err", 128'(err), 128'd1);
    check("oor_data", rd, 128'd0);
    check("oor_mem_quiet", 128'(act0 - snap), 128'd0);
    check("oor_ready", 128'(req_ready[0]), 128'd1);

    // Response held by consumer back-pressure.
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h20; resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    lat = 1;
    while (!resp_valid[0] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat", 128'(lat), 128'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 128'(resp_valid[0]), 128'd1);
      check("hold_data", resp_data[0], D_A);
      check("hold_req_ready", 128'(req_ready[0]), 128'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("release_ready", 128'(req_ready[0]), 128'd1);
    check("release_valid", 128'(resp_valid[0]), 128'd0);

    // Reset during WAIT of a read: aborted, no response.
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h20;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    check("rstwait_ready", 128'(req_ready[0]), 128'd1);
    check("rstwait_valid", 128'(resp_valid[0]), 128'd0);
    @(posedge clk); #1;
    check("rstwait_no_resp", 128'(resp_valid[0]), 128'd0);
    do_req(0, 1'b1, 32'h30, D_D, lat, rd, err);
    check("wr30_lat", 128'(lat), 128'd4);
    check("wr30_data", rd, 128'd0);
    do_req(0, 1'b0, 32'h30, '0, lat, rd, err);
    check("rd30_data", rd, D_D);
    check("rd30_err", 128'(err), 128'd0);

    // Reset at the edge ending ACCESS: the write still commits.
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 32'h40; req_data[0] = D_E;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("access_we", 128'(mem_we[0]), 128'd1);
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    check("rstacc_valid", 128'(resp_valid[0]), 128'd0);
    check("rstacc_we", 128'(mem_we[0]), 128'd0);
    do_req(0, 1'b0, 32'h40, '0, lat, rd, err);
    check("rd40_data", rd, D_E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
